// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, PPROT bit positions and the
// response record returned to the command initiator.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    // rdata is sized for the widest supported bus (32 bits)
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_wait_timer.sv
// Saturating ACCESS wait-cycle counter; last_wait flags that one more wait
// cycle would reach LIMIT.
module apb_master_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic inc,
    output logic last_wait
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge pclk) begin
        if (!presetn || clear) begin
            count <= '0;
        end else if (inc && count != CW'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign last_wait = (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB4/APB5 requester: valid/ready command stream in, one registered response
// per command out. Define APB_MASTER_TIMEOUT_EN to enable the wait-state abort.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    input  logic                    cmd_nse,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pnse,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwakeup,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr,
    output logic [1:0]              state_dbg
);

    // Command handshake: a command transfers on any edge where
    // cmd_valid && cmd_ready; cmd_ready is high in IDLE and in the ACCESS
    // cycle that completes (pready=1), allowing back-to-back SETUP.
    apb_state_e state;
    apb_rsp_t   rsp_q;
    logic       run_q;
    logic       accept;
    logic       done;
    logic       timeout_hit;

    assign done      = (state == ST_ACCESS) && pready;
    assign cmd_ready = run_q && ((state == ST_IDLE) || done);
    assign accept    = cmd_valid && cmd_ready;
    assign pwakeup   = psel | cmd_valid;
    assign state_dbg = state;

    assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    logic last_wait;

    apb_master_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .pclk      (pclk),
        .presetn   (presetn),
        .clear     (state != ST_ACCESS),
        .inc       ((state == ST_ACCESS) && !pready),
        .last_wait (last_wait)
    );

    assign timeout_hit = (state == ST_ACCESS) && !pready && last_wait;
`else
    // No abort without the timer; the limit only matters when it is built in
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            paddr  <= '0;
            pprot  <= '0;
            pnse   <= 1'b0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pprot  <= cmd_prot;
            pnse   <= cmd_nse;
            pwrite <= cmd_write;
            if (cmd_write) pwdata <= cmd_wdata;
            pstrb  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            run_q     <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            run_q     <= 1'b1;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SETUP;
                        psel  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        rsp_valid     <= 1'b1;
                        rsp_q.err     <= pslverr;
                        rsp_q.timeout <= 1'b0;
                        rsp_q.rdata   <= pwrite ? 32'd0 : 32'(prdata);
                        penable       <= 1'b0;
                        if (accept) begin
                            state <= ST_SETUP;
                        end else begin
                            state <= ST_IDLE;
                            psel  <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid     <= 1'b1;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        rsp_q.rdata   <= 32'd0;
                        penable       <= 1'b0;
                        psel          <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of single transfers plus
// hand-written back-to-back, timeout and mid-transfer reset sequences.
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        cmd_nse;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        pnse;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel;
    logic        penable;
    logic        pwakeup;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [1:0]  state_dbg;

    int tests;
    int failed;
    logic [31:0] last_wdata;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    apb_master #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .cmd_nse     (cmd_nse),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pprot       (pprot),
        .pnse        (pnse),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .psel        (psel),
        .penable     (penable),
        .pwakeup     (pwakeup),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr),
        .state_dbg   (state_dbg)
    );

    // Clock and reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        cmd_prot  = v.prot;
        cmd_nse   = v.nse;
    endtask

    task automatic chk_req(input vec_t v, input string tag);
        chk({tag, " paddr"}, 32'(paddr), 32'(v.addr));
        chk({tag, " pwrite"}, 32'(pwrite), 32'(v.write));
        chk({tag, " pstrb"}, 32'(pstrb), v.write ? 32'(v.strb) : 32'd0);
        chk({tag, " pwdata"}, pwdata, v.write ? v.wdata : last_wdata);
        chk({tag, " pprot"}, 32'(pprot), 32'(v.prot));
        chk({tag, " pnse"}, 32'(pnse), 32'(v.nse));
    endtask

    // One complete transfer from IDLE back to IDLE, with v.waits pready=0 cycles
    task automatic do_xfer(input vec_t v, input string tag);
        @(negedge pclk);
        drive_cmd(v);
        pready = 1'b0;
        #1 chk({tag, " idle ready"}, 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        #1;
        chk({tag, " setup psel"}, 32'(psel), 32'd1);
        chk({tag, " setup penable"}, 32'(penable), 32'd0);
        chk({tag, " setup state"}, 32'(state_dbg), 32'(ST_SETUP));
        chk({tag, " setup ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, " setup pwakeup"}, 32'(pwakeup), 32'd1);
        chk_req(v, {tag, " setup"});
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge pclk);
            pready  = (w == v.waits);
            prdata  = pready ? v.prdata : 32'h0BAD_F00D;
            pslverr = pready ? v.slverr : 1'b0;
            #1;
            chk({tag, " access psel"}, 32'(psel), 32'd1);
            chk({tag, " access penable"}, 32'(penable), 32'd1);
            chk({tag, " access rsp_valid"}, 32'(rsp_valid), 32'd0);
            chk({tag, " access ready"}, 32'(cmd_ready), 32'(pready));
            chk_req(v, {tag, " access"});
        end
        @(negedge pclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        #1;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({tag, " end psel"}, 32'(psel), 32'd0);
        chk({tag, " end penable"}, 32'(penable), 32'd0);
        if (v.write) last_wdata = v.wdata;
    endtask

    initial begin
        vec_t bv;
        tests      = 0;
        failed     = 0;
        last_wdata = 32'h0;

        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 16'h0010, 32'h0,        4'hF, 3'b000, 1'b0, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 16'h0020, 32'h0,        4'h0, 3'b001, 1'b0, 0, 32'h12345678, 1'b1, 32'h12345678, 1'b1};
        vecs[3] = '{1'b1, 16'h00FF, 32'hCAFE0001, 4'h5, 3'b101, 1'b1, 2, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 32'h11111111, 4'hF, 3'b010, 1'b1, 1, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 16'h1234, 32'h00000000, 4'h8, 3'b111, 1'b0, 0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};

        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        cmd_nse   = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        repeat (3) @(negedge pclk);
        #1;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset psel", 32'(psel), 32'd0);
        chk("reset penable", 32'(penable), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset pwakeup", 32'(pwakeup), 32'd0);
        chk("reset paddr", 32'(paddr), 32'd0);
        chk("reset pwdata", pwdata, 32'd0);
        chk("reset state", 32'(state_dbg), 32'(ST_IDLE));
        presetn = 1'b1;
        #1 chk("release ready early", 32'(cmd_ready), 32'd0);
        @(negedge pclk);
        #1 chk("release ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Four back-to-back writes with cmd_valid held high
        bv = vecs[0];
        bv.waits = 0;
        @(negedge pclk);
        bv.wdata = 32'h1000_0000;
        bv.addr  = 16'h0100;
        drive_cmd(bv);
        pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            #1;
            chk($sformatf("b2b%0d setup psel", k), 32'(psel), 32'd1);
            chk($sformatf("b2b%0d setup penable", k), 32'(penable), 32'd0);
            chk($sformatf("b2b%0d setup paddr", k), 32'(paddr), 32'h0100 + 32'(k * 4));
            chk($sformatf("b2b%0d setup rsp_valid", k), 32'(rsp_valid), (k > 0) ? 32'd1 : 32'd0);
            @(negedge pclk);
            #1;
            chk($sformatf("b2b%0d access psel", k), 32'(psel), 32'd1);
            chk($sformatf("b2b%0d access penable", k), 32'(penable), 32'd1);
            chk($sformatf("b2b%0d access pwdata", k), pwdata, 32'h1000_0000 + 32'(k));
            chk($sformatf("b2b%0d access rsp_valid", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("b2b%0d access ready", k), 32'(cmd_ready), 32'd1);
            if (k < 3) begin
                bv.addr  = 16'h0100 + 16'((k + 1) * 4);
                bv.wdata = 32'h1000_0000 + 32'(k + 1);
                drive_cmd(bv);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        @(negedge pclk);
        pready = 1'b0;
        #1;
        chk("b2b last rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b last rsp_err", 32'(rsp_err), 32'd0);
        chk("b2b end psel", 32'(psel), 32'd0);
        last_wdata = 32'h1000_0003;

`ifdef APB_MASTER_TIMEOUT_EN
        // Completer never answers: abort after four wait cycles
        bv = vecs[1];
        @(negedge pclk);
        drive_cmd(bv);
        @(negedge pclk);
        cmd_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            @(negedge pclk);
            #1;
            chk($sformatf("tmo wait%0d penable", w), 32'(penable), 32'd1);
            chk($sformatf("tmo wait%0d rsp_valid", w), 32'(rsp_valid), 32'd0);
        end
        @(negedge pclk);
        #1;
        chk("tmo rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("tmo rsp_rdata", rsp_rdata, 32'd0);
        chk("tmo psel", 32'(psel), 32'd0);
        do_xfer(vecs[2], "after_tmo");
`endif

        // Reset asserted while the completer is stalling
        bv = vecs[4];
        @(negedge pclk);
        drive_cmd(bv);
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        #1 chk("midrst access penable", 32'(penable), 32'd1);
        presetn = 1'b0;
        @(negedge pclk);
        #1;
        chk("midrst psel", 32'(psel), 32'd0);
        chk("midrst penable", 32'(penable), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst state", 32'(state_dbg), 32'(ST_IDLE));
        presetn = 1'b1;
        @(negedge pclk);
        #1;
        chk("midrst release ready", 32'(cmd_ready), 32'd1);
        chk("midrst no rsp", 32'(rsp_valid), 32'd0);
        last_wdata = 32'h0;
        do_xfer(vecs[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
